// File: rtl/multi_zone_light_control.sv
// Multi-zone lighting controller: per-zone debounced color cycling,
// sunlight-driven target luminosity with hysteresis, rate-limited ramp,
// and a global color-sync strobe that copies zone 0's color everywhere.
module multi_zone_light_control #(
  parameter int unsigned ZONES           = 4,
  parameter int unsigned SENSOR_W        = 8,
  parameter int unsigned NUM_COLORS      = 4,
  parameter int unsigned TH_HIGH         = 15,
  parameter int unsigned TH_MID          = 30,
  parameter int unsigned TH_OFF          = 50,
  parameter int unsigned HYST            = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned RAMP_CYCLES     = 8,
  localparam int unsigned COLOR_W        = $clog2(NUM_COLORS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [ZONES-1:0]            color_button,
  input  logic [ZONES*SENSOR_W-1:0]   sunlight_sensor,
  input  logic                        sync_colors,
  output logic [2*ZONES-1:0]          luminosity,
  output logic [COLOR_W*ZONES-1:0]    color,
  output logic [ZONES-1:0]            ramping
);

  localparam int unsigned SENS_MAX = (1 << SENSOR_W) - 1;
  localparam int unsigned DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RAMP_W   = (RAMP_CYCLES > 1) ? $clog2(RAMP_CYCLES) : 1;

  localparam logic [1:0] LUM_OFF  = 2'b00;
  localparam logic [1:0] LUM_LOW  = 2'b01;
  localparam logic [1:0] LUM_MID  = 2'b10;
  localparam logic [1:0] LUM_HIGH = 2'b11;

  // Threshold raised by the hysteresis band, clamped at full scale
  function automatic int unsigned sat_up(input int unsigned th);
    return (th + HYST > SENS_MAX) ? SENS_MAX : th + HYST;
  endfunction

  // Threshold lowered by the hysteresis band, clamped at zero
  function automatic int unsigned sat_dn(input int unsigned th);
    return (th > HYST) ? th - HYST : 0;
  endfunction

  localparam logic [SENSOR_W-1:0] HI_UP  = SENSOR_W'(sat_up(TH_HIGH));
  localparam logic [SENSOR_W-1:0] HI_DN  = SENSOR_W'(sat_dn(TH_HIGH));
  localparam logic [SENSOR_W-1:0] MID_UP = SENSOR_W'(sat_up(TH_MID));
  localparam logic [SENSOR_W-1:0] MID_DN = SENSOR_W'(sat_dn(TH_MID));
  localparam logic [SENSOR_W-1:0] OFF_UP = SENSOR_W'(sat_up(TH_OFF));
  localparam logic [SENSOR_W-1:0] OFF_DN = SENSOR_W'(sat_dn(TH_OFF));

  // Zone 0's registered color, broadcast on sync_colors
  logic [COLOR_W-1:0] zone0_color;
  assign zone0_color = color[COLOR_W-1:0];

  for (genvar z = 0; z < ZONES; z++) begin : g_zone
    logic [1:0]          sync_q;
    logic                db_q, db_d;
    logic [DB_W-1:0]     db_cnt_q, db_cnt_d;
    logic                press_c;
    logic [COLOR_W-1:0]  color_q, color_d;
    logic [1:0]          tgt_q, tgt_d;
    logic [1:0]          lum_q, lum_d;
    logic [RAMP_W-1:0]   ramp_cnt_q, ramp_cnt_d;
    logic                ramping_q, ramping_d;
    logic [SENSOR_W-1:0] sens;
    logic [SENSOR_W-1:0] eff_hi, eff_mid, eff_off;

    assign sens = sunlight_sensor[z*SENSOR_W +: SENSOR_W];

    // Debounce: accept a level after DEBOUNCE_CYCLES consecutive mismatches
    always_comb begin
      db_d     = db_q;
      db_cnt_d = '0;
      press_c  = 1'b0;
      if (sync_q[1] != db_q) begin
        if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          db_d    = ~db_q;
          press_c = ~db_q;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
    end

    // Color: sync overrides (and swallows) a same-edge press
    always_comb begin
      color_d = color_q;
      if (sync_colors) begin
        color_d = zone0_color;
      end else if (press_c) begin
        color_d = (color_q == COLOR_W'(NUM_COLORS - 1)) ? '0 : color_q + COLOR_W'(1);
      end
    end

    // Target classification with thresholds shifted away from the current target
    always_comb begin
      eff_hi  = (tgt_q == LUM_HIGH) ? HI_UP  : HI_DN;
      eff_mid = (tgt_q >= LUM_MID)  ? MID_UP : MID_DN;
      eff_off = (tgt_q >= LUM_LOW)  ? OFF_UP : OFF_DN;
      if (sens < eff_hi) begin
        tgt_d = LUM_HIGH;
      end else if (sens < eff_mid) begin
        tgt_d = LUM_MID;
      end else if (sens < eff_off) begin
        tgt_d = LUM_LOW;
      end else begin
        tgt_d = LUM_OFF;
      end
    end

    // Ramp: one level toward the current target every RAMP_CYCLES edges
    always_comb begin
      lum_d      = lum_q;
      ramp_cnt_d = '0;
      if (lum_q != tgt_q) begin
        if (ramp_cnt_q == RAMP_W'(RAMP_CYCLES - 1)) begin
          lum_d = (tgt_q > lum_q) ? lum_q + 2'd1 : lum_q - 2'd1;
        end else begin
          ramp_cnt_d = ramp_cnt_q + RAMP_W'(1);
        end
      end
      ramping_d = (lum_d != tgt_d);
    end

    // Per-zone state registers
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        sync_q     <= '0;
        db_q       <= 1'b0;
        db_cnt_q   <= '0;
        color_q    <= '0;
        tgt_q      <= LUM_OFF;
        lum_q      <= LUM_OFF;
        ramp_cnt_q <= '0;
        ramping_q  <= 1'b0;
      end else begin
        sync_q     <= {sync_q[0], color_button[z]};
        db_q       <= db_d;
        db_cnt_q   <= db_cnt_d;
        color_q    <= color_d;
        tgt_q      <= tgt_d;
        lum_q      <= lum_d;
        ramp_cnt_q <= ramp_cnt_d;
        ramping_q  <= ramping_d;
      end
    end

    assign luminosity[2*z +: 2]         = lum_q;
    assign color[COLOR_W*z +: COLOR_W]  = color_q;
    assign ramping[z]                   = ramping_q;
  end

endmodule

// File: doc/multi_zone_light_control.md
# multi_zone_light_control

Parametrised successor to the single-room light controller. It drives ZONES independent lighting zones. Each zone has a debounced color-cycle button, a sunlight-driven target luminosity with hysteresis, and a rate-limited luminosity ramp. A global color-sync command copies zone 0's color to every zone. The block sits between the per-room sensor/button front-ends and the lamp drivers.

## Interface
- ZONES, 4: number of independent zones (>=1)
- SENSOR_W, 8: sunlight sensor width per zone
- NUM_COLORS, 4: colors in the cycle (>=2); COLOR_W = $clog2(NUM_COLORS), derived, not overridable
- TH_HIGH, 15 / TH_MID, 30 / TH_OFF, 50: luminosity thresholds (TH_HIGH < TH_MID < TH_OFF < 2^SENSOR_W)
- HYST, 2: hysteresis band applied either side of each threshold
- DEBOUNCE_CYCLES, 4: stable cycles required to accept a button level change (>=1)
- RAMP_CYCLES, 8: cycles per one-level luminosity step (>=1)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- color_button  in  ZONES  per-zone raw push button, asynchronous to clk
- sunlight_sensor  in  ZONES*SENSOR_W  per-zone sensor value; zone k at [k*SENSOR_W +: SENSOR_W]
- sync_colors  in  1  synchronous single-cycle strobe: all zones take zone 0's color
- luminosity  out  2*ZONES  per-zone level; 11 HIGH, 10 MID, 01 LOW, 00 OFF
- color  out  COLOR_W*ZONES  per-zone color index
- ramping  out  ZONES  per-zone flag, high while luminosity != target

## Operation
- Reset (reset=0, no clock needed):
  - all color = 0, luminosity = 00, internal target = 00, ramping = 0
  - synchronizers, debounce state/counters and ramp counters clear to 0
- Button path, per zone:
  - 2-flop synchronizer, then debouncer.
  - The debounce counter increments while the synchronized level differs from the debounced level; it clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
  - A 0->1 flip of the debounced level advances color by 1, with wrap from NUM_COLORS-1 to 0.
  - Release or hold never advances color again.
- Target classification, per zone, registered:
  - For each threshold T, the effective threshold is T+HYST if the current target is brighter than that boundary, otherwise T-HYST.
  - T+HYST saturates at 2^SENSOR_W-1; T-HYST saturates at 0.
  - Classification: sensor < effHIGH -> HIGH; else < effMID -> MID; else < effOFF -> LOW; else OFF.
  - The target may jump several levels in one cycle.
- Ramp, per zone:
  - While luminosity != target, the ramp counter increments.
  - When the counter reaches RAMP_CYCLES-1, luminosity moves one level toward target and the counter clears.
  - When luminosity == target, the counter is held at 0.
  - If the target changes mid-ramp, the counter is not cleared; the direction is re-evaluated every cycle.
  - ramping = (luminosity != target), registered alongside luminosity.
- Color is independent of luminosity; presses are honored at OFF.
- sync_colors:
  - On that edge, every zone's color is loaded with zone 0's pre-edge color.
  - sync takes priority over any same-edge button advance in any zone, including zone 0; that press is consumed and lost.
  - sync does not affect debounce state.

## Timing
- Button: with color_button held high, color changes on the (DEBOUNCE_CYCLES+2)th rising edge that samples it high (2 sync + DEBOUNCE_CYCLES). Pulses shorter than DEBOUNCE_CYCLES synchronized cycles are ignored.
- Sensor -> target: 1 edge.
- Target -> first luminosity step: RAMP_CYCLES edges later. Each further step takes another RAMP_CYCLES edges.
- Full OFF->HIGH ramp: 3*RAMP_CYCLES edges.
- RAMP_CYCLES=1 steps every edge; DEBOUNCE_CYCLES=1 gives a 3-edge button latency.
- Async reset asserted mid-ramp or mid-debounce forces reset values immediately. After deassertion, the first edge re-evaluates target from the current sensor values.
- All outputs are registered; no combinational input-to-output paths.

## Test plan
- Reset release, all sensors=20, defaults:
  - target MID at edge 1
  - luminosity 00->01 at edge 9, 01->10 at edge 17
  - ramping 1 from edge 1 until edge 17, then 0
- Zone 1 button held 10 cycles:
  - color[1] 00->01 on the 6th high-sampled edge; other zones unchanged
  - four full presses return it to 00; a 3-cycle glitch changes nothing
- Hysteresis, zone 0 settled HIGH (sensor 10):
  - sensor 16 -> stays HIGH; sensor 17 -> target MID
  - back to 14 -> stays MID; 12 -> HIGH
  - sensor 255 -> target OFF in one edge, luminosity steps down one level per 8 edges
- Mid-ramp retarget: ramp OFF->HIGH interrupted at LOW by sensor 40 (target LOW) -> holds LOW, ramping drops to 0 the same edge.
- Sync: zone 0 color=10, zone 2 press completing on the same edge as sync_colors -> all zones read 10, zone 2 not advanced.
- Async reset asserted between clock edges mid-ramp -> luminosity=00, color=00, ramping=0 before the next edge.
